// File: rtl/sel_demux.sv
// Routes a synchronised, active-low 3-bit bus into one of three held
// channel registers, chosen by a debounced active-low switch.
module sel_demux #(
  parameter int W           = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic [W-1:0] iData,
  input  logic         iEn,
  input  logic [1:0]   iSw,
  output logic [W-1:0] oA,
  output logic [W-1:0] oB,
  output logic [W-1:0] oC,
  output logic [1:0]   oSel,
  output logic [2:0]   oStb
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACTIVE
  } state_e;

  logic [SYNC_STAGES-1:0][W-1:0] d_sync_q;
  logic [SYNC_STAGES-1:0]        e_sync_q;
  logic [SYNC_STAGES-1:0][1:0]   s_sync_q;

  logic [W-1:0] sd;
  logic         se;
  logic [1:0]   ss;

  logic [1:0]    ss_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  state_e       state_q, state_d;
  logic [1:0]   sel_q, sel_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] c_q, c_d;
  logic [2:0]   stb_q, stb_d;

  // Pins are inverted on entry so everything below is active-high.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      d_sync_q <= '0;
      e_sync_q <= '0;
      s_sync_q <= '0;
    end else begin
      d_sync_q[0] <= ~iData;
      e_sync_q[0] <= ~iEn;
      s_sync_q[0] <= ~iSw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        d_sync_q[i] <= d_sync_q[i-1];
        e_sync_q[i] <= e_sync_q[i-1];
        s_sync_q[i] <= s_sync_q[i-1];
      end
    end
  end

  assign sd = d_sync_q[SYNC_STAGES-1];
  assign se = e_sync_q[SYNC_STAGES-1];
  assign ss = s_sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d = cnt_q;
    if (ss != ss_prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CMAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ss_prev_q <= '0;
      cnt_q     <= '0;
    end else begin
      ss_prev_q <= ss;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    stb_d   = 3'b000;
    unique case (state_q)
      IDLE: begin
        if (ss != 2'd0) state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CMAX) begin
          sel_d   = ss;
          state_d = (ss != 2'd0) ? ACTIVE : IDLE;
        end
      end
      ACTIVE: begin
        if (ss != sel_q) begin
          state_d = SETTLE;
        end else if (se) begin
          unique case (1'b1)
            (sel_q == 2'd1): begin
              a_d   = sd;
              stb_d = 3'b001;
            end
            (sel_q == 2'd2): begin
              b_d   = sd;
              stb_d = 3'b010;
            end
            (sel_q == 2'd3): begin
              c_d   = sd;
              stb_d = 3'b100;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      stb_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      stb_q   <= stb_d;
    end
  end

  assign oA   = ~a_q;
  assign oB   = ~b_q;
  assign oC   = ~c_q;
  assign oSel = ~sel_q;
  assign oStb = ~stb_q;

endmodule

// File: tb/tb_sel_demux.sv
// Randomised scoreboard bench for sel_demux against a
// behavioural routing model.
module tb_sel_demux;

  localparam int SS  = 2;
  localparam int DEB = 4;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic [2:0] iData = 3'b111;
  logic       iEn = 1'b1;
  logic [1:0] iSw = 2'b11;
  logic [2:0] oA, oB, oC;
  logic [1:0] oSel;
  logic [2:0] oStb;

  int n_tests = 0;
  int n_fail  = 0;

  sel_demux #(
    .W(3),
    .SYNC_STAGES(SS),
    .DEB_CYCLES(DEB)
  ) dut (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .iData(iData),
    .iEn(iEn),
    .iSw(iSw),
    .oA(oA),
    .oB(oB),
    .oC(oC),
    .oSel(oSel),
    .oStb(oStb)
  );

  always #5 iClk = ~iClk;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [2:0] d;
    logic       e;
    logic [1:0] s;
  } pin_t;

  typedef struct packed {
    logic [1:0] ch;
    logic [2:0] d;
  } wr_t;

  pin_t       hist[$];
  wr_t        exp_q[$];
  int         m_run;
  logic [1:0] m_prev;
  logic [1:0] m_acc;
  bit         m_settle;
  logic [2:0] m_ch[3];

  // Reference: synced view is the pin sample SS edges old; the
  // select is re-accepted once it has been steady DEB cycles.
  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      hist = {};
      for (int i = 0; i < SS; i++) hist.push_back('0);
      exp_q    = {};
      m_run    = 0;
      m_prev   = 0;
      m_acc    = 0;
      m_settle = 0;
      for (int i = 0; i < 3; i++) m_ch[i] = 3'd0;
    end else begin
      pin_t cur;
      pin_t nw;
      cur  = hist[SS-1];
      nw.d = ~iData;
      nw.e = ~iEn;
      nw.s = ~iSw;
      hist.push_front(nw);
      void'(hist.pop_back());
      if (m_settle) begin
        if (m_run == DEB) begin
          m_acc    = cur.s;
          m_settle = 0;
        end
      end else if (cur.s != m_acc) begin
        m_settle = 1;
      end else if (m_acc != 0 && cur.e) begin
        m_ch[m_acc-1] = cur.d;
        exp_q.push_back({m_acc, cur.d});
      end
      if (cur.s != m_prev) m_run = 0;
      else if (m_run < DEB) m_run++;
      m_prev = cur.s;
    end
  end

  // Monitor: every cycle the strobe must match the next queued
  // write (or be idle), and the pins must match the model.
  always @(negedge iClk) begin
    if (iRst_n) begin
      logic [2:0] exp_stb;
      logic [2:0] got;
      wr_t w;
      exp_stb = 3'b111;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        exp_stb = ~(3'b001 << (w.ch - 2'd1));
        got = (w.ch == 2'd1) ? oA : (w.ch == 2'd2) ? oB : oC;
        chk("wr_data", {5'd0, got}, {5'd0, ~w.d});
      end
      chk("stb", {5'd0, oStb}, {5'd0, exp_stb});
      chk("oA", {5'd0, oA}, {5'd0, ~m_ch[0]});
      chk("oB", {5'd0, oB}, {5'd0, ~m_ch[1]});
      chk("oC", {5'd0, oC}, {5'd0, ~m_ch[2]});
      chk("oSel", {6'd0, oSel}, {6'd0, ~m_acc});
    end
  end

  task automatic chk_reset_pins(string nm);
    chk({nm, "_A"}, {5'd0, oA}, 8'h07);
    chk({nm, "_B"}, {5'd0, oB}, 8'h07);
    chk({nm, "_C"}, {5'd0, oC}, 8'h07);
    chk({nm, "_sel"}, {6'd0, oSel}, 8'h03);
    chk({nm, "_stb"}, {5'd0, oStb}, 8'h07);
  endtask

  task automatic pulse_rst(string nm);
    @(negedge iClk);
    #2 iRst_n = 1'b0;
    #1 chk_reset_pins(nm);
    @(posedge iClk);
    @(posedge iClk);
    #2 iRst_n = 1'b1;
  endtask

  task automatic drive(logic [1:0] sw, logic en, logic [2:0] d, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iClk);
      iSw = sw;
      iEn = en;
      iData = d;
    end
  endtask

  initial begin
    repeat (3) @(posedge iClk);
    #2 iRst_n = 1'b1;
    chk_reset_pins("por");

    pulse_rst("rst1");

    drive(2'b10, 1'b0, 3'b010, 14);
    @(negedge iClk);
    chk("routeA_A", {5'd0, oA}, 8'h02);
    chk("routeA_B", {5'd0, oB}, 8'h07);
    chk("routeA_sel", {6'd0, oSel}, 8'h02);
    chk("routeA_stb", {5'd0, oStb}, 8'h06);

    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 3'b101, 2);
    end
    @(negedge iClk);
    chk("bounce_sel", {6'd0, oSel}, 8'h02);
    chk("bounce_A", {5'd0, oA}, 8'h02);

    drive(2'b10, 1'b0, 3'b100, 14);
    drive(2'b01, 1'b0, 3'b100, 14);
    @(negedge iClk);
    chk("swAB_A", {5'd0, oA}, 8'h04);
    chk("swAB_B", {5'd0, oB}, 8'h04);
    chk("swAB_sel", {6'd0, oSel}, 8'h01);

    pulse_rst("rst2");
    for (int i = 0; i < 16; i++) begin
      drive(2'b11, 1'b0, 3'($urandom_range(0, 7)), 1);
    end
    @(negedge iClk);
    chk_reset_pins("none");

    drive(2'b00, 1'b0, 3'b011, 14);
    pulse_rst("rst3");
    drive(2'b00, 1'b0, 3'b110, 14);

    for (int s = 0; s < 60; s++) begin
      logic [1:0] sw;
      int len;
      sw  = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        drive(sw, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1);
      end
    end

    drive(2'b11, 1'b1, 3'b111, 12);
    chk("drain", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
